rc2014_bus_slave: RTL and testbench
===================================

// Module: rc2014_bus_slave
// PURPOSE
//  Parametrised RC2014 bus target, successor to the fixed-function bus test top.
//  Synchronises the Z80 strobes into fpga_clk and filters glitches on them.
//  Decodes memory and I/O cycles against configurable windows.
//  Serves memory reads from an external sync ROM and I/O reads/writes via a
//  strobe port; drives D and the level-shifter direction; counts cycles; toggles LED1.
// PARAMETERS
//  SYNC_STAGES   2        synchroniser flops per bus strobe (>=2)
//  GLITCH_CYCLES 3        consecutive stable fpga_clk samples needed to accept an edge (1..15)
//  ROM_BASE      16'h0000 ROM window base; must be aligned to 2^ROM_AW
//  ROM_AW        13       ROM address width; window size is 2^ROM_AW bytes
//  IO_BASE       8'h80    I/O window base on A[7:0]; must be aligned to 2^IO_AW
//  IO_AW         3        I/O window address width (2^IO_AW ports)
//  CNT_W         16       width of cycle_count
//  LED_DIV       0        LED1 toggles once per 2^LED_DIV decoded cycles
// PORTS
//  fpga_clk    in   1       system clock; all logic on its rising edge
//  RST         in   1       asynchronous reset, active low
//  A           in   16      Z80 address bus
//  D_in        in   8       Z80 data bus, input path
//  D_out       out  8       data driven onto the bus
//  D_oe        out  1       1 = D_out is driving the bus
//  MRQ,IORQ    in   1 each  active-low bus request strobes
//  RD,WR,M1    in   1 each  active-low bus control strobes
//  DATA_DIR    out  1       level-shifter direction: 1 = FPGA to bus; equals D_oe
//  ADDR_DIR    out  1       fixed 0 (address lines are inputs only)
//  rom_addr    out  ROM_AW  ROM read address
//  rom_rdata   in   8       ROM data; valid 1 cycle after rom_addr is presented
//  io_wr_stb   out  1       1-cycle pulse on a decoded I/O write
//  io_addr     out  IO_AW   I/O port index; valid with io_wr_stb and during I/O reads
//  io_wr_data  out  8       captured write data; valid with io_wr_stb
//  io_rd_data  in   8       combinational read data for io_addr
//  cycle_count out  CNT_W   count of decoded cycles; wraps at 2^CNT_W
//  LED1        out  1       activity toggle
// BEHAVIOUR
//  Reset (RST=0, async): every synchroniser stage and filter reads strobes as inactive (1).
//   FSM = IDLE; D_oe=0, DATA_DIR=0, D_out=0, io_wr_stb=0, io_addr=0, rom_addr=0.
//   cycle_count=0, LED1=0; LED prescaler=0; ADDR_DIR is always 0.
//  Filtering: a synced strobe changes its filtered value only after GLITCH_CYCLES equal samples.
//   Decode uses filtered values only.
//  A and D_in are sampled on the cycle the FSM leaves IDLE; they are not synchronised.
//   The bus holds them stable while a strobe is asserted.
//  FSM states: IDLE, ROM_FETCH, DRIVE, IO_WRITE, HOLD.
//   IDLE -> ROM_FETCH: MRQ=0, RD=0, WR=1, A inside the ROM window; rom_addr <= A[ROM_AW-1:0].
//   IDLE -> DRIVE:     IORQ=0, RD=0, WR=1, M1=1, A[7:IO_AW] matches IO_BASE.
//                      D_out <= io_rd_data; D_oe <= 1 on the same edge.
//   IDLE -> IO_WRITE:  IORQ=0, WR=0, RD=1, decode matches; io_wr_data <= D_in.
//   ROM_FETCH -> DRIVE (next cycle): D_out <= rom_rdata; D_oe <= 1.
//   IO_WRITE -> HOLD (next cycle): io_wr_stb=1 for exactly this one cycle.
//   DRIVE -> HOLD when the filtered RD deasserts; D_oe drops on that same edge.
//   HOLD -> IDLE once MRQ, IORQ, RD and WR are all filtered high.
//  Bus-to-FPGA latency: filtered strobe to D_oe=1 is 1 cycle for I/O, 2 cycles for ROM.
//  cycle_count and the LED prescaler increment once per decoded cycle on leaving IDLE.
//   Decoded = ROM read, I/O read or I/O write. LED1 toggles when the prescaler wraps.
//  Boundaries:
//   - Address outside window, or memory write (MRQ & WR): IDLE->HOLD; no drive, no count.
//   - MRQ and IORQ both low, or RD and WR both low: malformed -> HOLD; no action.
//   - IORQ=0 with M1=0 (interrupt acknowledge): never driven -> HOLD.
//   - Strobe deasserts during ROM_FETCH: abort to HOLD; D_oe never asserts; count still increments.
//   - Reset mid-cycle: D_oe falls asynchronously; any pending io_wr_stb is suppressed.
//   - Wrap: cycle_count all-ones + 1 -> 0.
//   - No new cycle is accepted until HOLD completes; back-to-back cycles need strobes high first.
// TESTING
//  1 Reset: RST=0 mid-DRIVE -> D_oe=0 immediately; cycle_count=0; LED1=0; FSM=IDLE after release.
//  2 ROM read: A=16'h0123, MRQ=RD=0, rom_rdata=8'hC3
//    -> rom_addr=13'h0123; D_out=8'hC3 and D_oe=1 two cycles after filtered strobe.
//    -> D_oe=0 after RD rises; cycle_count=1.
//  3 I/O write: IORQ=WR=0, A[7:0]=8'h85, D_in=8'h5A
//    -> single io_wr_stb pulse, io_addr=3'd5, io_wr_data=8'h5A; D_oe stays 0.
//  4 Glitch: a 2-cycle RD low pulse with GLITCH_CYCLES=3 -> no state change, no count, D_oe=0.
//  5 Window miss and INTA: A=16'h2000 memory read; then IORQ=M1=0 at port 8'h80
//    -> no drive, cycle_count unchanged for both.
//  6 Counters: CNT_W=4, LED_DIV=1, 17 I/O reads -> cycle_count=1 after wrap; LED1=0 (8 toggles).

Source files
------------

// File: rtl/rc2014_bus_slave.sv
// rc2014_bus_slave: RC2014 bus target with strobe sync/filter, window decode, ROM and I/O service
module rc2014_bus_slave #(
  parameter int          SYNC_STAGES   = 2,
  parameter int          GLITCH_CYCLES = 3,
  parameter logic [15:0] ROM_BASE      = 16'h0000,
  parameter int          ROM_AW        = 13,
  parameter logic [7:0]  IO_BASE       = 8'h80,
  parameter int          IO_AW         = 3,
  parameter int          CNT_W         = 16,
  parameter int          LED_DIV       = 0
) (
  input  logic              fpga_clk,
  input  logic              RST,
  input  logic [15:0]       A,
  input  logic [7:0]        D_in,
  output logic [7:0]        D_out,
  output logic              D_oe,
  input  logic              MRQ,
  input  logic              IORQ,
  input  logic              RD,
  input  logic              WR,
  input  logic              M1,
  output logic              DATA_DIR,
  output logic              ADDR_DIR,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [7:0]        rom_rdata,
  output logic              io_wr_stb,
  output logic [IO_AW-1:0]  io_addr,
  output logic [7:0]        io_wr_data,
  input  logic [7:0]        io_rd_data,
  output logic [CNT_W-1:0]  cycle_count,
  output logic              LED1
);
  typedef enum logic [2:0] {IDLE, ROM_FETCH, DRIVE, IO_WRITE, HOLD} state_t;
  state_t state;
  logic [4:0] raw, f;
  logic mrq, iorq, rd, wr, m1;
  logic rom_hit, io_hit, mem_rd, io_rd, io_wr, start;
  logic [LED_DIV:0] psc;
  assign raw = {M1, WR, RD, IORQ, MRQ};
  assign {m1, wr, rd, iorq, mrq} = f;
  for (genvar i = 0; i < 5; i++) begin : g_strobe
    logic [SYNC_STAGES-1:0] sr;
    logic [3:0] n;
    logic q;
    // Synchronise one strobe, then accept a new level only after it has been stable long enough
    always_ff @(posedge fpga_clk or negedge RST)
      if (!RST) begin
        sr <= '1;
        n  <= '0;
        q  <= 1'b1;
      end else begin
        sr <= {sr[SYNC_STAGES-2:0], raw[i]};
        if (sr[SYNC_STAGES-1] == q) n <= '0;
        else if (n == 4'(GLITCH_CYCLES - 1)) begin
          q <= sr[SYNC_STAGES-1];
          n <= '0;
        end else n <= n + 1'b1;
      end
    assign f[i] = q;
  end
  assign rom_hit  = A[15:ROM_AW] == ROM_BASE[15:ROM_AW];
  assign io_hit   = A[7:IO_AW] == IO_BASE[7:IO_AW];
  assign mem_rd   = !mrq && iorq && !rd && wr && rom_hit;
  assign io_rd    = !iorq && mrq && !rd && wr && m1 && io_hit;
  assign io_wr    = !iorq && mrq && rd && !wr && m1 && io_hit;
  assign start    = !iorq || (!mrq && (!rd || !wr));
  assign DATA_DIR = D_oe;
  assign ADDR_DIR = 1'b0;
  assign LED1     = psc[LED_DIV];
  // Bus cycle sequencer; io_addr follows A while idle so io_rd_data is ready on the decode edge
  always_ff @(posedge fpga_clk or negedge RST)
    if (!RST) begin
      state       <= IDLE;
      D_out       <= '0;
      D_oe        <= 1'b0;
      io_wr_stb   <= 1'b0;
      io_addr     <= '0;
      io_wr_data  <= '0;
      rom_addr    <= '0;
      cycle_count <= '0;
      psc         <= '0;
    end else begin
      io_wr_stb <= 1'b0;
      case (state)
        IDLE: begin
          io_addr <= A[IO_AW-1:0];
          if (mem_rd) begin
            state    <= ROM_FETCH;
            rom_addr <= A[ROM_AW-1:0];
          end else if (io_rd) begin
            state <= DRIVE;
            D_out <= io_rd_data;
            D_oe  <= 1'b1;
          end else if (io_wr) begin
            state      <= IO_WRITE;
            io_wr_data <= D_in;
          end else if (start) state <= HOLD;
          if (mem_rd || io_rd || io_wr) begin
            cycle_count <= cycle_count + 1'b1;
            psc         <= psc + 1'b1;
          end
        end
        ROM_FETCH:
          if (!mrq && !rd) begin
            state <= DRIVE;
            D_out <= rom_rdata;
            D_oe  <= 1'b1;
          end else state <= HOLD;
        DRIVE:
          if (rd) begin
            state <= HOLD;
            D_oe  <= 1'b0;
          end
        IO_WRITE: begin
          io_wr_stb <= 1'b1;
          state     <= HOLD;
        end
        HOLD: if (mrq && iorq && rd && wr) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_rc2014_bus_slave.sv
// tb_rc2014_bus_slave: randomized bus cycles against a transaction-level model of the target
module tb_rc2014_bus_slave;
  logic fpga_clk = 0, RST = 0;
  logic [15:0] A = 0;
  logic [7:0] D_in = 0, D_out, rom_rdata, io_wr_data, io_rd_data;
  logic D_oe, DATA_DIR, ADDR_DIR, io_wr_stb, LED1;
  logic MRQ = 1, IORQ = 1, RD = 1, WR = 1, M1 = 1;
  logic [12:0] rom_addr;
  logic [2:0] io_addr;
  logic [3:0] cycle_count;
  int checks = 0, errors = 0, exp_cnt = 0;
  logic [12:0] exp_rom_addr = 0;
  logic [7:0] rom_val = 0;
  logic [7:0] io_regs [8];
  always #5 fpga_clk = ~fpga_clk;
  assign rom_rdata  = (rom_addr == exp_rom_addr) ? rom_val : 8'h00;
  assign io_rd_data = io_regs[io_addr];
  rc2014_bus_slave #(.CNT_W(4), .LED_DIV(1)) dut (
    .fpga_clk(fpga_clk), .RST(RST), .A(A), .D_in(D_in), .D_out(D_out), .D_oe(D_oe),
    .MRQ(MRQ), .IORQ(IORQ), .RD(RD), .WR(WR), .M1(M1), .DATA_DIR(DATA_DIR), .ADDR_DIR(ADDR_DIR),
    .rom_addr(rom_addr), .rom_rdata(rom_rdata), .io_wr_stb(io_wr_stb), .io_addr(io_addr),
    .io_wr_data(io_wr_data), .io_rd_data(io_rd_data), .cycle_count(cycle_count), .LED1(LED1)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask
  task automatic idle_bus;
    {MRQ, IORQ, RD, WR, M1} = 5'b11111;
  endtask
  task automatic do_reset;
    @(negedge fpga_clk);
    RST = 0;
    idle_bus();
    exp_cnt = 0;
    repeat (3) @(negedge fpga_clk);
    RST = 1;
    repeat (3) @(negedge fpga_clk);
  endtask
  // k: 0 mem read, 1 mem write, 2 io read, 3 io write, 4 inta, 5 glitched RD, 6 malformed
  task automatic run(input int k, input logic [15:0] a, input logic [7:0] d, input logic [7:0] rv);
    logic drv, wrc, dec, hit, saw, dd_ok, oe_end;
    logic [7:0] ed, dout, wdata;
    logic [2:0] waddr;
    int lat_exp, lat, stb;
    hit = a[7:0] >= 8'h80 && a[7:0] <= 8'h87;
    drv = 0; wrc = 0; dec = 0; ed = 0; lat_exp = 0;
    if (k == 0 && a < 16'h2000) begin drv = 1; dec = 1; ed = rv; lat_exp = 7; end
    if (k == 2 && hit) begin drv = 1; dec = 1; ed = io_regs[int'(a[7:0]) - 128]; lat_exp = 6; end
    if (k == 3 && hit) begin wrc = 1; dec = 1; end
    saw = 0; dd_ok = 1; lat = 0; stb = 0; dout = 0; wdata = 0; waddr = 0; oe_end = 0;
    A = a; D_in = d; rom_val = rv; exp_rom_addr = a[12:0];
    @(posedge fpga_clk); #2;
    case (k)
      0: {MRQ, RD} = 2'b00;
      1: {MRQ, WR} = 2'b00;
      2: {IORQ, RD} = 2'b00;
      3: {IORQ, WR} = 2'b00;
      4: {IORQ, M1} = 2'b00;
      5: MRQ = 0;
      default: {MRQ, IORQ, RD} = 3'b000;
    endcase
    if (k == 5) begin
      @(posedge fpga_clk); #2 RD = 0;
      repeat (2) @(posedge fpga_clk);
      #2 RD = 1;
    end
    for (int n = 1; n <= 14; n++) begin
      @(posedge fpga_clk); @(negedge fpga_clk);
      if (D_oe && !saw) begin saw = 1; lat = n; dout = D_out; end
      if (io_wr_stb) begin stb++; waddr = io_addr; wdata = io_wr_data; end
      dd_ok &= DATA_DIR === D_oe;
    end
    @(posedge fpga_clk); #2 idle_bus();
    for (int n = 0; n < 12; n++) begin
      @(posedge fpga_clk); @(negedge fpga_clk);
      if (io_wr_stb) stb++;
      dd_ok &= DATA_DIR === D_oe;
      oe_end = D_oe;
    end
    if (dec) exp_cnt++;
    chk($sformatf("drive k%0d", k), saw, drv);
    if (drv) begin
      chk($sformatf("latency k%0d", k), lat, lat_exp);
      chk($sformatf("dout k%0d", k), dout, ed);
    end
    if (k == 0 && drv) chk("rom_addr", rom_addr, a[12:0]);
    chk($sformatf("stb_count k%0d", k), stb, wrc ? 1 : 0);
    if (wrc) begin
      chk("io_addr", waddr, a[2:0]);
      chk("io_wr_data", wdata, d);
    end
    chk("oe_released", oe_end, 0);
    chk("data_dir", dd_ok, 1);
    chk($sformatf("count k%0d", k), cycle_count, exp_cnt % 16);
    chk($sformatf("led k%0d", k), LED1, (exp_cnt / 2) % 2);
  endtask
  initial begin
    int stb;
    logic [15:0] a;
    for (int i = 0; i < 8; i++) io_regs[i] = 8'($urandom);
    repeat (3) @(negedge fpga_clk);
    chk("rst_oe", D_oe, 0);
    chk("rst_dout", D_out, 0);
    chk("rst_count", cycle_count, 0);
    chk("rst_led", LED1, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_io_addr", io_addr, 0);
    chk("rst_stb", io_wr_stb, 0);
    chk("addr_dir", ADDR_DIR, 0);
    RST = 1;
    repeat (3) @(negedge fpga_clk);
    A = 16'h0081;
    {IORQ, RD} = 2'b00;
    for (int n = 0; n < 20 && !D_oe; n++) @(negedge fpga_clk);
    chk("oe_before_reset", D_oe, 1);
    #1 RST = 0;
    #1 chk("async_oe", D_oe, 0);
    chk("async_count", cycle_count, 0);
    chk("async_led", LED1, 0);
    idle_bus();
    exp_cnt = 0;
    repeat (2) @(negedge fpga_clk);
    RST = 1;
    repeat (3) @(negedge fpga_clk);
    A = 16'h0083; D_in = 8'hE7;
    @(posedge fpga_clk); #2 {IORQ, WR} = 2'b00;
    repeat (6) @(posedge fpga_clk);
    #1 RST = 0;
    idle_bus();
    stb = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge fpga_clk);
      if (io_wr_stb) stb++;
    end
    chk("stb_suppressed", stb, 0);
    chk("reset_count", cycle_count, 0);
    RST = 1;
    repeat (3) @(negedge fpga_clk);
    run(0, 16'h0123, 8'h00, 8'hC3);
    chk("rom_first_count", cycle_count, 1);
    run(3, 16'h0085, 8'h5A, 8'h00);
    run(5, 16'h0040, 8'h00, 8'h11);
    run(0, 16'h2000, 8'h00, 8'h22);
    run(4, 16'h0080, 8'h00, 8'h00);
    chk("miss_inta_count", cycle_count, 2);
    for (int t = 0; t < 50; t++) begin
      int k;
      k = $urandom_range(0, 6);
      a = 16'($urandom);
      if (k == 0 && $urandom_range(0, 1) == 1) a[15:13] = 3'b000;
      if ((k == 2 || k == 3) && $urandom_range(0, 2) != 0) a[7:3] = 5'b10000;
      run(k, a, 8'($urandom), 8'($urandom_range(1, 255)));
    end
    do_reset();
    for (int t = 0; t < 17; t++) begin
      a = 16'($urandom);
      a[7:3] = 5'b10000;
      run(2, a, 8'h00, 8'h00);
    end
    chk("wrap_count", cycle_count, 1);
    chk("wrap_led", LED1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
